// File: rtl/transform_sched_pkg.sv
// Shared encodings for the residual inverse-transform sequencer: states,
// block-type codes and per-phase cycle-count lookup.
package transform_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DHT  = 3'd1,
    ST_IQ   = 3'd2,
    ST_IDCT = 3'd3,
    ST_ZERO = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    BT_NONE  = 3'd0,
    BT_L16DC = 3'd1,
    BT_L16AC = 3'd2,
    BT_L4X4  = 3'd3,
    BT_L8X8  = 3'd4,
    BT_CDC   = 3'd5,
    BT_CAC   = 3'd6,
    BT_RSVD  = 3'd7
  } blk_type_e;

  typedef enum logic [1:0] {
    PH_DHT  = 2'd0,
    PH_IQ   = 2'd1,
    PH_IDCT = 2'd2
  } phase_e;

  typedef struct packed {
    logic [7:0] dht16;
    logic [7:0] dht2;
    logic [7:0] iq4;
    logic [7:0] iq8;
    logic [7:0] idct4;
    logic [7:0] idct8;
  } cyc_cfg_t;

  // Length in cycles of a phase for a given block type; 8x8 only widens IQ/IDCT.
  function automatic logic [7:0] phase_len(input logic [2:0] bt, input phase_e ph,
                                           input cyc_cfg_t cfg);
    logic [7:0] len;
    len = 8'd1;
    case (ph)
      PH_DHT:  len = (bt == BT_L16DC) ? cfg.dht16 : cfg.dht2;
      PH_IQ:   len = (bt == BT_L8X8) ? cfg.iq8 : cfg.iq4;
      PH_IDCT: len = (bt == BT_L8X8) ? cfg.idct8 : cfg.idct4;
      default: len = 8'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/transform_sched.sv
// Sequencer for the DHT -> IQ -> IDCT residual datapath with a zero-block
// shortcut and out_valid/out_ready handshake allowing back-to-back blocks.
//
// state | meaning
// IDLE  | waiting for start
// DHT   | DC Hadamard (luma 4x4 or chroma 2x2)
// IQ    | inverse quantisation
// IDCT  | inverse transform (4x4 or 8x8)
// ZERO  | all-zero block, single write cycle
// DONE  | result held until out_ready
module transform_sched
  import transform_sched_pkg::*;
#(
  parameter int QP_W       = 6,
  parameter int CNT_W      = 4,
  parameter int DHT16_CYC  = 8,
  parameter int DHT2_CYC   = 1,
  parameter int DHT_RD_CYC = 4,
  parameter int IQ4_CYC    = 4,
  parameter int IQ8_CYC    = 16,
  parameter int IDCT4_CYC  = 8,
  parameter int IDCT8_CYC  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [2:0]       blk_type_in,
  input  logic             cc_in,
  input  logic [6:0]       total_coeff,
  input  logic [3:0]       blk_idx_in,
  input  logic [QP_W-1:0]  qp_y,
  input  logic [QP_W-1:0]  qp_cb,
  input  logic [QP_W-1:0]  qp_cr,
  input  logic             out_ready,
  output logic [2:0]       state,
  output logic [2:0]       block_type,
  output logic [CNT_W-1:0] counter,
  output logic [QP_W-1:0]  curr_qp,
  output logic [3:0]       dc_rd_idx,
  output logic             dht_wr,
  output logic             iq_wr,
  output logic             dc_wr,
  output logic             idct_wr,
  output logic             zero_wr,
  output logic             rd,
  output logic             out_valid,
  output logic             busy
);

  localparam cyc_cfg_t CFG = '{
    dht16: 8'(DHT16_CYC), dht2: 8'(DHT2_CYC), iq4: 8'(IQ4_CYC),
    iq8: 8'(IQ8_CYC), idct4: 8'(IDCT4_CYC), idct8: 8'(IDCT8_CYC)
  };
  localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(DHT_RD_CYC);

  state_e           state_q, state_d, ld_state;
  logic [2:0]       bt_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, ld_cnt;
  logic [QP_W-1:0]  qp_q, qp_sel;
  logic             valid_q;
  logic             acc, zero_blk, dc_blk_in, dc_blk_q;

  assign acc = ena & start & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign dc_blk_in = (blk_type_in == BT_L16DC) | (blk_type_in == BT_CDC);
  assign dc_blk_q  = (bt_q == BT_L16DC) | (bt_q == BT_CDC);

  // Only AC-carrying types can skip on an empty block; DC blocks always run.
  assign zero_blk = (blk_type_in == BT_NONE) | (blk_type_in == BT_RSVD) |
                    ((total_coeff == 7'd0) &
                     ((blk_type_in == BT_L16AC) | (blk_type_in == BT_L4X4) |
                      (blk_type_in == BT_L8X8)  | (blk_type_in == BT_CAC)));

  always_comb begin
    ld_state = ST_IQ;
    ld_cnt   = CNT_W'(phase_len(blk_type_in, PH_IQ, CFG) - 8'd1);
    if (zero_blk) begin
      ld_state = ST_ZERO;
      ld_cnt   = '0;
    end else if (dc_blk_in) begin
      ld_state = ST_DHT;
      ld_cnt   = CNT_W'(phase_len(blk_type_in, PH_DHT, CFG) - 8'd1);
    end
    qp_sel = ((blk_type_in >= 3'd1) && (blk_type_in <= 3'd4)) ? qp_y
           : (cc_in ? qp_cr : qp_cb);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (acc) begin
        state_d = ld_state;
        cnt_d   = ld_cnt;
      end
      ST_DHT: if (cnt_q == '0) begin
        state_d = ST_IQ;
        cnt_d   = CNT_W'(phase_len(bt_q, PH_IQ, CFG) - 8'd1);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      ST_IQ: if (cnt_q == '0) begin
        if (dc_blk_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDCT;
          cnt_d   = CNT_W'(phase_len(bt_q, PH_IDCT, CFG) - 8'd1);
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      ST_IDCT: if (cnt_q == '0) state_d = ST_DONE;
               else cnt_d = cnt_q - 1'b1;
      ST_ZERO: state_d = ST_DONE;
      ST_DONE: if (acc) begin
        state_d = ld_state;
        cnt_d   = ld_cnt;
      end else if (out_ready) begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bt_q    <= '0;
      cnt_q   <= '0;
      qp_q    <= '0;
      valid_q <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == ST_DONE);
      if (acc) begin
        bt_q <= blk_type_in;
        qp_q <= qp_sel;
      end
    end
  end

  always_comb begin
    dc_rd_idx = 4'd0;
    if (blk_type_in == BT_L16AC)   dc_rd_idx = blk_idx_in;
    else if (blk_type_in == BT_CAC) dc_rd_idx = {1'b0, cc_in, blk_idx_in[1:0]};
  end

  assign state      = state_q;
  assign block_type = bt_q;
  assign counter    = cnt_q;
  assign curr_qp    = qp_q;
  assign out_valid  = valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign dht_wr     = (state_q == ST_DHT);
  assign iq_wr      = (state_q == ST_IQ);
  assign dc_wr      = (state_q == ST_IQ) & dc_blk_q;
  assign idct_wr    = (state_q == ST_IDCT);
  assign zero_wr    = (state_q == ST_ZERO);
  assign rd         = ((state_q == ST_DHT) & (cnt_q < RD_LIM)) |
                      (state_q == ST_IQ) | (state_q == ST_IDCT);

endmodule

// File: tb/tb_transform_sched.sv
// Scoreboard bench for transform_sched: expected per-block latency, QP and
// strobe counts are queued at issue and compared when out_valid rises.
module tb_transform_sched;

  logic       clk = 1'b0;
  logic       rst_n, ena, start, cc_in, out_ready;
  logic [2:0] blk_type_in;
  logic [6:0] total_coeff;
  logic [3:0] blk_idx_in;
  logic [5:0] qp_y, qp_cb, qp_cr;
  logic [2:0] state, block_type;
  logic [3:0] counter, dc_rd_idx;
  logic [5:0] curr_qp;
  logic       dht_wr, iq_wr, dc_wr, idct_wr, zero_wr, rd, out_valid, busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int bt, qp, lat, dht, dht_rd, iq, dc, idct, zero, rd;
  } exp_t;
  exp_t sb[$];

  transform_sched dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .blk_type_in(blk_type_in), .cc_in(cc_in), .total_coeff(total_coeff),
    .blk_idx_in(blk_idx_in), .qp_y(qp_y), .qp_cb(qp_cb), .qp_cr(qp_cr),
    .out_ready(out_ready), .state(state), .block_type(block_type),
    .counter(counter), .curr_qp(curr_qp), .dc_rd_idx(dc_rd_idx),
    .dht_wr(dht_wr), .iq_wr(iq_wr), .dc_wr(dc_wr), .idct_wr(idct_wr),
    .zero_wr(zero_wr), .rd(rd), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int bt, input int tc, input int cc);
    exp_t e;
    bit   zero;
    e = '{default: 0};
    e.bt = bt;
    e.qp = (bt >= 1 && bt <= 4) ? int'(qp_y) : (cc != 0 ? int'(qp_cr) : int'(qp_cb));
    zero = (bt == 0) || (bt == 7) ||
           ((bt == 2 || bt == 3 || bt == 4 || bt == 6) && tc == 0);
    if (zero) begin
      e.zero = 1;
      e.lat  = 2;
    end else begin
      e.dht    = (bt == 1) ? 8 : (bt == 5) ? 1 : 0;
      e.dht_rd = (bt == 1) ? 4 : (bt == 5) ? 1 : 0;
      e.iq     = (bt == 4) ? 16 : 4;
      e.dc     = (bt == 1 || bt == 5) ? e.iq : 0;
      e.idct   = (bt == 1 || bt == 5) ? 0 : (bt == 4) ? 16 : 8;
      e.rd     = e.dht_rd + e.iq + e.idct;
      e.lat    = 1 + e.dht + e.iq + e.idct;
    end
    return e;
  endfunction

  task automatic drive(input int bt, input int cc, input int tc);
    blk_type_in = 3'(bt);
    cc_in       = cc[0];
    total_coeff = 7'(tc);
    start       = 1'b1;
  endtask

  task automatic issue(input int bt, input int cc, input int tc);
    drive(bt, cc, tc);
    sb.push_back(model(bt, tc, cc));
    step();
    start = 1'b0;
  endtask

  // Called one cycle after the accepting edge; returns with out_valid high.
  task automatic wait_done(input string tag);
    exp_t e;
    int n, c_dht, c_iq, c_dc, c_idct, c_zero, c_rd, c_dht_rd, c_rd_pat;
    n = 1; c_dht = 0; c_iq = 0; c_dc = 0; c_idct = 0; c_zero = 0;
    c_rd = 0; c_dht_rd = 0; c_rd_pat = 0;
    chk({tag, "_sb_pending"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      while (!out_valid && n < 200) begin
        if (dht_wr) begin
          if (rd !== (c_dht >= e.dht - e.dht_rd)) c_rd_pat++;
          if (rd) c_dht_rd++;
          c_dht++;
        end
        if (iq_wr)   c_iq++;
        if (dc_wr)   c_dc++;
        if (idct_wr) c_idct++;
        if (zero_wr) c_zero++;
        if (rd)      c_rd++;
        step();
        n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(e.lat));
      chk({tag, "_block_type"}, 32'(block_type), 32'(e.bt));
      chk({tag, "_curr_qp"}, 32'(curr_qp), 32'(e.qp));
      chk({tag, "_done_state"}, 32'(state), 32'd5);
      chk({tag, "_dht_cycles"}, 32'(c_dht), 32'(e.dht));
      chk({tag, "_dht_rd"}, 32'(c_dht_rd), 32'(e.dht_rd));
      chk({tag, "_dht_rd_pattern"}, 32'(c_rd_pat), 0);
      chk({tag, "_iq_cycles"}, 32'(c_iq), 32'(e.iq));
      chk({tag, "_dc_wr"}, 32'(c_dc), 32'(e.dc));
      chk({tag, "_idct_cycles"}, 32'(c_idct), 32'(e.idct));
      chk({tag, "_zero_cycles"}, 32'(c_zero), 32'(e.zero));
      chk({tag, "_rd_cycles"}, 32'(c_rd), 32'(e.rd));
    end
  endtask

  task automatic release_blk(input string tag);
    out_ready = 1'b1;
    step();
    chk({tag, "_idle"}, {29'd0, state}, 32'd0);
    chk({tag, "_valid_clr"}, 32'(out_valid), 0);
  endtask

  function automatic logic [22:0] out_vec();
    return {state, block_type, counter, curr_qp, out_valid, busy,
            dht_wr, iq_wr, dc_wr, idct_wr, zero_wr, rd};
  endfunction

  initial begin
    int k;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; out_ready = 1'b1;
    blk_type_in = 3'd0; cc_in = 1'b0; total_coeff = 7'd0; blk_idx_in = 4'd0;
    qp_y = 6'd28; qp_cb = 6'd20; qp_cr = 6'd33;
    #23;
    chk("reset_outputs", 32'(out_vec()), 0);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", 32'(out_vec()), 0);

    blk_type_in = 3'd2; blk_idx_in = 4'd9; cc_in = 1'b0; #1;
    chk("dc_idx_luma_ac", 32'(dc_rd_idx), 9);
    blk_type_in = 3'd6; blk_idx_in = 4'd14; cc_in = 1'b1; #1;
    chk("dc_idx_chroma_ac", 32'(dc_rd_idx), 6);
    blk_type_in = 3'd3; #1;
    chk("dc_idx_other", 32'(dc_rd_idx), 0);

    issue(3, 0, 5);
    chk("busy_running", 32'(busy), 1);
    wait_done("l4x4");
    release_blk("l4x4");

    issue(1, 0, 16);
    wait_done("l16dc");
    release_blk("l16dc");
    issue(5, 1, 4);
    wait_done("cdc_cr");
    release_blk("cdc_cr");

    issue(4, 0, 64);
    wait_done("l8x8");
    release_blk("l8x8");
    issue(4, 0, 0);
    wait_done("l8x8_zero");
    release_blk("l8x8_zero");
    issue(7, 0, 10);
    wait_done("reserved");
    release_blk("reserved");

    out_ready = 1'b0;
    issue(3, 0, 5);
    wait_done("hold");
    for (int i = 0; i < 10; i++) begin
      drive(2, 0, 4);
      step();
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_state", 32'(state), 5);
      chk("hold_type", 32'(block_type), 3);
    end
    drive(6, 0, 3);
    out_ready = 1'b1;
    sb.push_back(model(6, 3, 0));
    step();
    start = 1'b0;
    chk("b2b_state_iq", 32'(state), 2);
    chk("b2b_valid_drop", 32'(out_valid), 0);
    wait_done("b2b_cac");
    release_blk("b2b_cac");

    drive(3, 0, 5);
    step();
    start = 1'b0;
    k = 0;
    while (!(state == 3'd3 && counter == 4'd3) && k < 50) begin
      step();
      k++;
    end
    chk("freeze_reached_at", 32'(k), 8);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; out_ready = i[0];
      step();
      chk("freeze_hold", {22'd0, state, counter, idct_wr, rd, out_valid}, 32'b0110011110);
    end
    start = 1'b0; out_ready = 1'b1; ena = 1'b1;
    k = 0;
    while (!out_valid && k < 50) begin
      step();
      k++;
    end
    chk("freeze_resume_cycles", 32'(k), 4);
    chk("freeze_resume_qp", 32'(curr_qp), 28);
    release_blk("freeze");

    issue(1, 0, 16);
    step();
    step();
    chk("pre_reset_dht", 32'(dht_wr), 1);
    void'(sb.pop_front());
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'(out_vec()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", 32'(out_vec()), 0);
    qp_cb = 6'd17;
    issue(6, 0, 2);
    wait_done("post_reset_cac");
    release_blk("post_reset_cac");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
